fsm_ctrl_param: RTL and testbench

//  Parametrised successor of the switch's FSM control block: sequences the datapath through

---
 rtl/fsm_ctrl_param.sv | 143 ++++++++++++++
 tb/tb_fsm_ctrl_param.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fsm_ctrl_param.sv
// fsm_ctrl_param: switch control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) for NUM_FIFOS FIFOs.
// Latches per-FIFO thresholds in INIT, reports idle/active from FIFO empty flags, and
// captures FIFO errors into a sticky vector.
// Optional feature macro: FSM_ERR_AUTOCLR_EN -- leave ERROR after ERR_CLR_CYC clean cycles.
module fsm_ctrl_param #(
  parameter int unsigned NUM_FIFOS   = 5,
  parameter int unsigned TH_W        = 4,
  parameter int unsigned ERR_CLR_CYC = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init,
  input  logic [NUM_FIFOS*TH_W-1:0] umbral_in,
  input  logic [NUM_FIFOS-1:0]      FIFO_empty,
  input  logic [NUM_FIFOS-1:0]      FIFO_error,
  output logic [NUM_FIFOS*TH_W-1:0] umbrales_I,
  output logic                      active,
  output logic                      idle,
  output logic [NUM_FIFOS-1:0]      error,
  output logic [2:0]                state
);

  localparam int unsigned TOT_W = NUM_FIFOS * TH_W;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  // A zero clear count would make the auto-clear counter meaningless.
  if (ERR_CLR_CYC == 0) begin : g_bad_cfg
    $error("ERR_CLR_CYC must be at least 1");
  end

  state_t               r_state;
  state_t               w_state_nxt;
  logic [TOT_W-1:0]     r_umbr;
  logic [TOT_W-1:0]     w_umbr_nxt;
  logic [NUM_FIFOS-1:0] r_error;
  logic [NUM_FIFOS-1:0] w_error_nxt;
  logic                 r_active;
  logic                 r_idle;
  logic                 w_any_err;
  logic                 w_all_empty;

`ifdef FSM_ERR_AUTOCLR_EN
  localparam int unsigned CNT_W = $clog2(ERR_CLR_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ERR_CLR_CYC - 1);

  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] w_err_cnt_nxt;
`endif

  assign w_any_err   = |FIFO_error;
  assign w_all_empty = &FIFO_empty;

  // Next-state, threshold and error-vector computation.
  always_comb begin
    w_state_nxt = r_state;
    w_umbr_nxt  = r_umbr;
    w_error_nxt = r_error;
`ifdef FSM_ERR_AUTOCLR_EN
    w_err_cnt_nxt = r_err_cnt;
`endif
    case (r_state)
      S_RESET: w_state_nxt = S_INIT;
      S_INIT: begin
        w_umbr_nxt  = umbral_in;
        w_state_nxt = init ? S_INIT : S_IDLE;
      end
      S_IDLE, S_ACTIVE: begin
        if (w_any_err) begin
          w_state_nxt = S_ERROR;
          w_error_nxt = FIFO_error;
`ifdef FSM_ERR_AUTOCLR_EN
          w_err_cnt_nxt = '0;
`endif
        end else if (init) begin
          w_state_nxt = S_INIT;
        end else if (r_state == S_IDLE && !w_all_empty) begin
          w_state_nxt = S_ACTIVE;
        end else if (r_state == S_ACTIVE && w_all_empty) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
`ifdef FSM_ERR_AUTOCLR_EN
        if (w_any_err) begin
          w_error_nxt   = r_error | FIFO_error;
          w_err_cnt_nxt = '0;
        end else if (r_err_cnt >= CNT_MAX) begin
          w_state_nxt   = S_IDLE;
          w_error_nxt   = '0;
          w_err_cnt_nxt = '0;
        end else begin
          w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
        end
`else
        w_error_nxt = r_error | FIFO_error;
`endif
      end
      default: w_state_nxt = S_RESET;
    endcase
  end

  // State and output registers; active/idle track the next state so they align with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_RESET;
      r_umbr   <= '0;
      r_error  <= '0;
      r_active <= 1'b0;
      r_idle   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_umbr   <= w_umbr_nxt;
      r_error  <= w_error_nxt;
      r_active <= (w_state_nxt == S_ACTIVE);
      r_idle   <= (w_state_nxt == S_IDLE);
    end
  end

`ifdef FSM_ERR_AUTOCLR_EN
  // Consecutive error-free cycle counter used while in ERROR.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_cnt <= '0;
    end else begin
      r_err_cnt <= w_err_cnt_nxt;
    end
  end
`endif

  assign umbrales_I = r_umbr;
  assign error      = r_error;
  assign active     = r_active;
  assign idle       = r_idle;
  assign state      = r_state;

endmodule

// File: tb/tb_fsm_ctrl_param.sv
// Directed, table-driven bench for fsm_ctrl_param (default parameters).
module tb_fsm_ctrl_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        init;
  logic [19:0] umbral_in;
  logic [4:0]  FIFO_empty;
  logic [4:0]  FIFO_error;
  logic [19:0] umbrales_I;
  logic        active;
  logic        idle;
  logic [4:0]  error;
  logic [2:0]  state;

  int n_tests = 0;
  int n_fail  = 0;

  fsm_ctrl_param #(
    .NUM_FIFOS  (5),
    .TH_W       (4),
    .ERR_CLR_CYC(4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .umbral_in (umbral_in),
    .FIFO_empty(FIFO_empty),
    .FIFO_error(FIFO_error),
    .umbrales_I(umbrales_I),
    .active    (active),
    .idle      (idle),
    .error     (error),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ini;
    logic [19:0] umb;
    logic [4:0]  emp;
    logic [4:0]  fer;
    logic [2:0]  st;
    logic [19:0] ut;
    logic [4:0]  er;
    logic        act;
    logic        idl;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
    n_tests++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act_v, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_to_idle(input logic [19:0] u);
    reset      = 1'b1;
    init       = 1'b0;
    FIFO_error = 5'h00;
    FIFO_empty = 5'h1F;
    umbral_in  = u;
    step();
    reset = 1'b0;
    step();
    step();
  endtask

  initial begin
    reset      = 1'b1;
    init       = 1'b0;
    umbral_in  = 20'h0;
    FIFO_empty = 5'h1F;
    FIFO_error = 5'h00;

    // columns: rst ini umbral_in empty fifo_err | state umbrales error active idle
    vecs[0]  = '{1'b0, 1'b1, 20'h12345, 5'h1F, 5'h00, 3'd1, 20'h00000, 5'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 20'h12345, 5'h1F, 5'h00, 3'd1, 20'h12345, 5'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 20'h12345, 5'h1F, 5'h00, 3'd1, 20'h12345, 5'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 20'h12345, 5'h1F, 5'h00, 3'd2, 20'h12345, 5'h00, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 20'hFFFFF, 5'h1F, 5'h00, 3'd2, 20'h12345, 5'h00, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 20'hFFFFF, 5'h1D, 5'h00, 3'd3, 20'h12345, 5'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 20'hFFFFF, 5'h1D, 5'h00, 3'd3, 20'h12345, 5'h00, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 20'hFFFFF, 5'h1F, 5'h00, 3'd2, 20'h12345, 5'h00, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 20'hFFFFF, 5'h1D, 5'h00, 3'd3, 20'h12345, 5'h00, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 20'hFFFFF, 5'h1D, 5'h14, 3'd4, 20'h12345, 5'h14, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 20'hFFFFF, 5'h1D, 5'h01, 3'd4, 20'h12345, 5'h15, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 20'hFFFFF, 5'h1D, 5'h00, 3'd4, 20'h12345, 5'h15, 1'b0, 1'b0};

    // Reset state, before any clock edge.
    #1;
    chk("reset state",  32'(state),      32'd0);
    chk("reset umbr",   32'(umbrales_I), 32'h0);
    chk("reset error",  32'(error),      32'h0);
    chk("reset active", 32'(active),     32'd0);
    chk("reset idle",   32'(idle),       32'd0);

    // Main sequence: INIT load, IDLE/ACTIVE toggling, error capture.
    for (int i = 0; i < 12; i++) begin
      reset      = vecs[i].rst;
      init       = vecs[i].ini;
      umbral_in  = vecs[i].umb;
      FIFO_empty = vecs[i].emp;
      FIFO_error = vecs[i].fer;
      step();
      chk($sformatf("v%0d state", i),  32'(state),      32'(vecs[i].st));
      chk($sformatf("v%0d umbr", i),   32'(umbrales_I), 32'(vecs[i].ut));
      chk($sformatf("v%0d error", i),  32'(error),      32'(vecs[i].er));
      chk($sformatf("v%0d active", i), 32'(active),     32'(vecs[i].act));
      chk($sformatf("v%0d idle", i),   32'(idle),       32'(vecs[i].idl));
    end
    FIFO_error = 5'h00;

`ifndef FSM_ERR_AUTOCLR_EN
    // ERROR is terminal: init held high for 50 cycles must not leave it.
    init = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step();
      chk($sformatf("terminal c%0d state", k), 32'(state), 32'd4);
    end
    chk("terminal error", 32'(error), 32'h15);
    init = 1'b0;
`else
    // Auto-clear: state returns to IDLE exactly 4 edges after the last error.
    reset_to_idle(20'h13579);
    FIFO_error = 5'h01;
    step();
    chk("ac enter state", 32'(state), 32'd4);
    FIFO_error = 5'h00;
    step();
    step();
    FIFO_error = 5'h02;
    step();
    chk("ac err2 state", 32'(state), 32'd4);
    chk("ac err2 error", 32'(error), 32'h03);
    FIFO_error = 5'h00;
    init = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk($sformatf("ac edge%0d state", k), 32'(state), 32'd4);
      chk($sformatf("ac edge%0d error", k), 32'(error), 32'h03);
    end
    init = 1'b0;
    step();
    chk("ac clear state", 32'(state), 32'd2);
    chk("ac clear error", 32'(error), 32'h00);
    chk("ac clear idle",  32'(idle),  32'd1);
    chk("ac clear umbr",  32'(umbrales_I), 32'h13579);
`endif

    // Error and init on the same edge: ERROR wins, thresholds untouched.
    reset_to_idle(20'hABCDE);
    chk("t6 idle state", 32'(state),      32'd2);
    chk("t6 idle umbr",  32'(umbrales_I), 32'hABCDE);
    init       = 1'b1;
    FIFO_error = 5'h04;
    umbral_in  = 20'h55555;
    step();
    chk("t6 state", 32'(state),      32'd4);
    chk("t6 umbr",  32'(umbrales_I), 32'hABCDE);
    chk("t6 error", 32'(error),      32'h04);
    init       = 1'b0;
    FIFO_error = 5'h00;

    // Async reset in the middle of ACTIVE, between clock edges.
    reset_to_idle(20'h2468A);
    FIFO_empty = 5'h1D;
    step();
    chk("t1 pre state",  32'(state),  32'd3);
    chk("t1 pre active", 32'(active), 32'd1);
    #3;
    reset = 1'b1;
    #1;
    chk("t1 state",  32'(state),      32'd0);
    chk("t1 umbr",   32'(umbrales_I), 32'h0);
    chk("t1 error",  32'(error),      32'h0);
    chk("t1 active", 32'(active),     32'd0);
    chk("t1 idle",   32'(idle),       32'd0);
    step();
    chk("t1 held state", 32'(state), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
